// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared FSM state type, membrane width and saturating-add helpers for lif_sched.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } lif_state_t;

    // Room for W_NUM full-scale weights plus headroom for the retained potential.
    function automatic int mem_width(input int w_wid, input int w_num);
        return w_wid + $clog2(w_num) + 2;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_upd.sv
// rtl/lif_upd.sv - combinational leak/integrate/threshold step for one neuron.
module lif_upd
    import lif_pkg::*;
#(
    parameter int W_WID = 8,
    parameter int W_NUM = 4,
    parameter int TAU   = 3,
    parameter int VTH   = 50,
    parameter int VRES  = 0,
    parameter int MW    = mem_width(W_WID, W_NUM)
) (
    input  logic [MW-1:0] v,
    input  logic [MW-1:0] acc,
    output logic [MW-1:0] v_next,
    output logic          spk
);

    logic [MW-1:0] leaked;
    logic [31:0]   sum;

    // v - (v >> TAU) never underflows, so only the add needs saturation.
    always_comb begin
        leaked = v - (v >> TAU);
        sum    = sat_add(32'(leaked), 32'(acc), MW);
        spk    = (sum >= 32'(VTH));
        v_next = spk ? MW'(VRES) : sum[MW-1:0];
    end

endmodule

// File: rtl/lif_sched.sv
// rtl/lif_sched.sv - time-multiplexed LIF neuron scheduler; define LIF_SCHED_REFRACT_EN for refractory counters.
module lif_sched
    import lif_pkg::*;
#(
    parameter  int W_WID = 8,
    parameter  int W_NUM = 4,
    parameter  int N_NEU = 2,
    parameter  int TAU   = 3,
    parameter  int VTH   = 50,
    parameter  int VRES  = 0,
    localparam int NW    = N_NEU * W_NUM,
    localparam int AW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_NUM-1:0] in_spk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_NEU-1:0] out_spk,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W_WID-1:0] cfg_wdata,
    output logic             busy
);

    localparam int MW = mem_width(W_WID, W_NUM);
    localparam int IW = (W_NUM > 1) ? $clog2(W_NUM) : 1;
    localparam int JW = (N_NEU > 1) ? $clog2(N_NEU) : 1;

    lif_state_t       state_q, state_d;
    logic [W_NUM-1:0] spk_q;
    logic [MW-1:0]    acc_q;
    logic [IW-1:0]    i_q;
    logic [JW-1:0]    j_q;
    logic [N_NEU-1:0] out_spk_q;
    logic [MW-1:0]    v_q [N_NEU];
    logic [W_WID-1:0] w_q [NW];
`ifdef LIF_SCHED_REFRACT_EN
    logic [1:0]       rcnt_q [N_NEU];
`endif

    logic             i_last, j_last;
    logic [AW-1:0]    widx;
    logic [MW-1:0]    acc_add;
    logic [MW-1:0]    upd_v;
    logic             upd_spk;

    assign i_last  = (i_q == IW'(W_NUM - 1));
    assign j_last  = (j_q == JW'(N_NEU - 1));
    assign widx    = AW'(int'(j_q) * W_NUM + int'(i_q));
    assign acc_add = acc_q + (spk_q[i_q] ? MW'(w_q[widx]) : '0);

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_spk   = out_spk_q;

    lif_upd #(
        .W_WID (W_WID),
        .W_NUM (W_NUM),
        .TAU   (TAU),
        .VTH   (VTH),
        .VRES  (VRES),
        .MW    (MW)
    ) u_upd (
        .v      (v_q[j_q]),
        .acc    (acc_q),
        .v_next (upd_v),
        .spk    (upd_spk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_ACCUM;
            ST_ACCUM:  if (i_last) state_d = ST_UPDATE;
            ST_UPDATE: state_d = j_last ? ST_DONE : ST_ACCUM;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Weights are only writable while idle, so a timestep always sees one consistent set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else if (state_q == ST_IDLE && cfg_we && int'(cfg_addr) < NW) begin
            w_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_q     <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            out_spk_q <= '0;
            for (int k = 0; k < N_NEU; k++) v_q[k] <= '0;
`ifdef LIF_SCHED_REFRACT_EN
            for (int k = 0; k < N_NEU; k++) rcnt_q[k] <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: if (in_valid) begin
                    spk_q     <= in_spk;
                    acc_q     <= '0;
                    i_q       <= '0;
                    j_q       <= '0;
                    out_spk_q <= '0;
                end
                ST_ACCUM: begin
                    acc_q <= acc_add;
                    i_q   <= i_last ? '0 : i_q + IW'(1);
                end
                ST_UPDATE: begin
`ifdef LIF_SCHED_REFRACT_EN
                    if (rcnt_q[j_q] != 2'd0) begin
                        rcnt_q[j_q]    <= rcnt_q[j_q] - 2'd1;
                        v_q[j_q]       <= MW'(VRES);
                        out_spk_q[j_q] <= 1'b0;
                    end else begin
                        v_q[j_q]       <= upd_v;
                        out_spk_q[j_q] <= upd_spk;
                        if (upd_spk) rcnt_q[j_q] <= 2'd2;
                    end
`else
                    v_q[j_q]       <= upd_v;
                    out_spk_q[j_q] <= upd_spk;
`endif
                    if (!j_last) begin
                        j_q   <= j_q + JW'(1);
                        i_q   <= '0;
                        acc_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_sched.sv
// tb/tb_lif_sched.sv - scoreboard bench for lif_sched against a behavioural LIF model.
module tb_lif_sched;

    localparam int W_NUM = 4;
    localparam int N_NEU = 2;
    localparam int NW    = W_NUM * N_NEU;
    localparam int TAU   = 3;
    localparam int VTH   = 50;
    localparam int VRES  = 0;
    localparam int VMAX  = 4095;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] in_spk = '0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       in_ready, out_valid, busy;
    logic [1:0] out_spk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];
    int mv[N_NEU];
    int mr[N_NEU];
    int mw[NW];

    lif_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_spk    (in_spk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_spk   (out_spk),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N_NEU; j++) begin mv[j] = 0; mr[j] = 0; end
        for (int k = 0; k < NW; k++) mw[k] = 0;
    endtask

    task automatic model_step(input logic [3:0] s, output logic [1:0] r);
        int acc, nv;
        r = '0;
        for (int j = 0; j < N_NEU; j++) begin
            acc = 0;
            for (int i = 0; i < W_NUM; i++) if (s[i]) acc += mw[j*W_NUM+i];
`ifdef LIF_SCHED_REFRACT_EN
            if (mr[j] != 0) begin
                mr[j]--;
                mv[j] = VRES;
                continue;
            end
`endif
            nv = mv[j] - (mv[j] >> TAU) + acc;
            if (nv > VMAX) nv = VMAX;
            if (nv >= VTH) begin
                r[j] = 1'b1;
                mv[j] = VRES;
                mr[j] = 2;
            end else begin
                mv[j] = nv;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 3'(a);
        cfg_wdata = 8'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        mw[a] = d;
    endtask

    // mode 0: plain; 1: cfg write coincident with handshake; 2: cfg write during ACCUM.
    task automatic step(input logic [3:0] s, input int hold, input int mode, input int a, input int d);
        logic [1:0] e, held;
        int lat, guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_spk = s;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 1);
            in_valid = 1'b0;
            return;
        end
        if (mode == 1) begin
            cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = 8'(d);
            mw[a] = d;
        end
        model_step(s, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (mode == 2 && lat == 2) begin
                cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = 8'(d);
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        cfg_we = 1'b0;
        check("latency", lat, 11);
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        held = out_spk;
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("hold_out_valid", {31'd0, out_valid}, 1);
                check("hold_out_spk", {30'd0, out_spk}, {30'd0, held});
                check("hold_in_ready", {31'd0, in_ready}, 0);
            end
            in_valid = 1'b0;
        end
        check("out_spk", {30'd0, out_spk}, {30'd0, exp_q.pop_front()});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_done", {31'd0, in_ready}, 1);
    endtask

    initial begin
        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_spk", {30'd0, out_spk}, 0);

        // All weights 20, all inputs on: both neurons fire on the first step.
        for (int k = 0; k < NW; k++) cfg_write(k, 20);
        step(4'b1111, 0, 0, 0, 0);

        // Single synapse: 20, 38, then 54 fires.
        do_reset();
        cfg_write(0, 20);
        for (int t = 0; t < 3; t++) step(4'b0001, 0, 0, 0, 0);

        // Backpressure in DONE with a pending in_valid.
        step(4'b0001, 20, 0, 0, 0);

        // Write while busy is dropped; write with the handshake is used.
        step(4'b0001, 0, 2, 0, 99);
        step(4'b0001, 0, 1, 0, 99);

        // Reset asserted in the third ACCUM cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_spk = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        check("midrst_out_spk", {30'd0, out_spk}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        step(4'b1111, 0, 0, 0, 0);
        cfg_write(0, 49);
        step(4'b0001, 0, 0, 0, 0);

        // Refractory behaviour (or plain firing) over four steps.
        do_reset();
        for (int k = 0; k < NW; k++) cfg_write(k, 20);
        for (int t = 0; t < 4; t++) step(4'b1111, 0, 0, 0, 0);

        // Random weights and spike patterns.
        do_reset();
        for (int k = 0; k < NW; k++) cfg_write(k, int'($urandom_range(0, 30)));
        for (int t = 0; t < 6; t++) step(4'($urandom_range(0, 15)), 0, 0, 0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lif_sched.md
LIF_SCHED -- requirements
Module: lif_sched

Interface
REQ-001 Parameter W_WID, default 8: weight and input-current width, unsigned.
REQ-002 Parameter W_NUM, default 4: synaptic inputs per neuron.
REQ-003 Parameter N_NEU, default 2: neurons time-multiplexed onto one shared LIF update datapath.
REQ-004 Parameter TAU, default 3: leak shift; leak = v >> TAU.
REQ-005 Parameter VTH, default 50: firing threshold; fire when v_next >= VTH.
REQ-006 Parameter VRES, default 0: post-spike membrane value.
REQ-007 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 Port in_valid, input, 1: in_spk holds one timestep's input spikes.
REQ-010 Port in_ready, output, 1: high only in IDLE.
REQ-011 Port in_spk, input, W_NUM: input spike vector, bit i = input i.
REQ-012 Port out_valid, output, 1: out_spk holds the finished timestep's result.
REQ-013 Port out_ready, input, 1: downstream accepts out_spk.
REQ-014 Port out_spk, output, N_NEU: output spike vector, bit j = neuron j.
REQ-015 Port cfg_we, input, 1: weight write strobe.
REQ-016 Port cfg_addr, input, clog2(N_NEU*W_NUM): address j*W_NUM+i.
REQ-017 Port cfg_wdata, input, W_WID: weight value.
REQ-018 Port busy, output, 1: high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ACCUM, UPDATE, DONE.
REQ-020 IDLE: on in_valid&&in_ready, latch in_spk, clear the accumulator, set neuron index to 0 and input index to 0, go to ACCUM.
REQ-021 ACCUM: each cycle, add weight[j][i] to the accumulator if latched spike bit i is 1; after i = W_NUM-1 go to UPDATE.
REQ-022 UPDATE: one cycle; v_next = v[j] - (v[j]>>TAU) + acc, computed at width W_WID+clog2(W_NUM)+2 and saturating at the all-ones value; if v_next >= VTH, set spk[j]=1 and v[j]=VRES, else set spk[j]=0 and v[j]=v_next.
REQ-023 After UPDATE, if j < N_NEU-1, increment j, clear i and the accumulator, and go to ACCUM; otherwise go to DONE.
REQ-024 Latency from input handshake to first out_valid cycle is exactly N_NEU*(W_NUM+1)+1 clocks; 11 clocks at defaults.
REQ-025 DONE: out_valid=1 with out_spk stable; on out_valid&&out_ready go to IDLE; out_ready low holds DONE indefinitely.
REQ-026 A cfg_we write in IDLE updates the weight at the next edge; cfg_we in any other state is ignored.
REQ-027 cfg_we coincident with the input handshake: the write takes effect and the timestep uses the new weight.
REQ-028 A cfg_addr >= N_NEU*W_NUM is ignored.
REQ-029 Membrane potentials persist across timesteps; they are cleared only by reset.

Reset
REQ-030 rst_n low at any time, including mid-ACCUM or in DONE, immediately forces IDLE, in_ready=1, out_valid=0, out_spk=0, busy=0, all v=0, all weights=0, and the accumulator and indices to 0; no partial result is emitted.

Configuration
REQ-031 With LIF_SCHED_REFRACT_EN defined, each neuron has a 2-bit refractory counter loaded with 2 on fire; while the counter is nonzero, UPDATE decrements it, holds v at VRES and forces spk=0.
REQ-032 Without LIF_SCHED_REFRACT_EN, no refractory logic exists and REQ-022 applies unchanged.

Structure
REQ-033 Package lif_pkg holds the FSM state enum, the membrane-width function and a saturating-add helper.
REQ-034 Sub-module lif_upd is the combinational leak/integrate/threshold step (v, acc -> v_next, spk), instantiated once.

Verification
REQ-035 Defaults, all weights 20, in_spk=4'b1111: out_spk[0]=1 at clock 11 after the handshake, and v[0]=0.
REQ-036 Weight[0][0]=20, others 0, in_spk=4'b0001 for 3 timesteps: v0 = 20, then 38, then fire on step 3 (54 >= 50), out_spk=2'b00, 2'b00, 2'b01.
REQ-037 Hold out_ready=0 for 20 cycles in DONE: out_valid and out_spk stay stable, in_ready=0, the next in_valid is not accepted.
REQ-038 Assert rst_n=0 during ACCUM cycle 3: in the same cycle, out_valid=0, busy=0 and in_ready=1; the next timestep starts from v=0 with weights=0.
REQ-039 cfg_we during ACCUM to address 0 with data 99: the weight is unchanged, confirmed by the next timestep's result.
REQ-040 With LIF_SCHED_REFRACT_EN defined, all weights 20, in_spk=4'b1111 for 4 steps: neuron 0 gives out_spk bits 1, 0, 0, 1.
